// File: rtl/eater_cpu.sv
// SAP-1 style 8-bit microcoded CPU: 16-byte RAM, A/B registers, add/sub ALU, carry/zero flags, output register.
// Optional macro EATER_CPU_DEMO_PROGRAM_EN preloads the demo program into RAM; otherwise RAM starts all zero.
module eater_cpu (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  bus,
    output logic [3:0]  mem_address_data,
    output logic [7:0]  mem_data,
    output logic [7:0]  a_data,
    output logic [7:0]  b_data,
    output logic [7:0]  alu_data,
    output logic [7:0]  instruction_data,
    output logic [7:0]  display_data,
    output logic [3:0]  pc_data,
    output logic [15:0] ctrl_state,
    output logic        ovf,
    output logic        zf
);

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

`ifdef EATER_CPU_DEMO_PROGRAM_EN
    logic [7:0] ram [16] = '{8'h1E, 8'h2F, 8'hE0, 8'hF0,
                             8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h1C, 8'h0E};
`else
    logic [7:0] ram [16] = '{default: 8'h00};
`endif

    logic [3:0]  pc_r;
    logic [3:0]  mar_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [7:0]  ir_r;
    logic [7:0]  out_r;
    logic        carry_r;
    logic        zero_r;
    logic [2:0]  step_r;

    logic [15:0] ctrl_s;
    logic [7:0]  bus_s;
    logic [8:0]  alu_sum_s;
    logic [7:0]  mem_rd_s;
    logic        halt_s;

    assign mem_rd_s = ram[mar_r];
    assign halt_s   = ctrl_s[B_HLT];

    // Microcode decode: fetch on T0/T1, opcode-specific steps on T2..T4.
    always_comb begin
        ctrl_s = 16'h0000;
        case (step_r)
            3'd0: ctrl_s = C_CO | C_MI;
            3'd1: ctrl_s = C_RO | C_II | C_CE;
            3'd2: begin
                case (ir_r[7:4])
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_s = C_IO | C_MI;
                    OP_LDI: ctrl_s = C_IO | C_AI;
                    OP_JMP: ctrl_s = C_IO | C_J;
                    OP_JC:  ctrl_s = carry_r ? (C_IO | C_J) : 16'h0000;
                    OP_JZ:  ctrl_s = zero_r  ? (C_IO | C_J) : 16'h0000;
                    OP_OUT: ctrl_s = C_AO | C_OI;
                    OP_HLT: ctrl_s = C_HLT;
                    default: ctrl_s = 16'h0000;
                endcase
            end
            3'd3: begin
                case (ir_r[7:4])
                    OP_LDA:         ctrl_s = C_RO | C_AI;
                    OP_ADD, OP_SUB: ctrl_s = C_RO | C_BI;
                    OP_STA:         ctrl_s = C_AO | C_RI;
                    default:        ctrl_s = 16'h0000;
                endcase
            end
            3'd4: begin
                case (ir_r[7:4])
                    OP_ADD:  ctrl_s = C_EO | C_AI | C_FI;
                    OP_SUB:  ctrl_s = C_EO | C_AI | C_SU | C_FI;
                    default: ctrl_s = 16'h0000;
                endcase
            end
            default: ctrl_s = 16'h0000;
        endcase
    end

    // Subtraction is A + ~B + 1, so carry=1 means "no borrow".
    always_comb begin
        if (ctrl_s[B_SU]) begin
            alu_sum_s = {1'b0, a_r} + {1'b0, ~b_r} + 9'd1;
        end else begin
            alu_sum_s = {1'b0, a_r} + {1'b0, b_r};
        end
    end

    // Bus multiplexer with fixed source priority in case microcode ever drives two.
    always_comb begin
        if (ctrl_s[B_CO]) begin
            bus_s = {4'h0, pc_r};
        end else if (ctrl_s[B_RO]) begin
            bus_s = mem_rd_s;
        end else if (ctrl_s[B_IO]) begin
            bus_s = {4'h0, ir_r[3:0]};
        end else if (ctrl_s[B_AO]) begin
            bus_s = a_r;
        end else if (ctrl_s[B_EO]) begin
            bus_s = alu_sum_s[7:0];
        end else begin
            bus_s = 8'h00;
        end
    end

    // Register file, flags, PC and microstep; everything freezes while HLT is asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= 4'h0;
            mar_r   <= 4'h0;
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            ir_r    <= 8'h00;
            out_r   <= 8'h00;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            step_r  <= 3'd0;
        end else if (!halt_s) begin
            if (ctrl_s[B_MI]) mar_r <= bus_s[3:0];
            if (ctrl_s[B_II]) ir_r  <= bus_s;
            if (ctrl_s[B_AI]) a_r   <= bus_s;
            if (ctrl_s[B_BI]) b_r   <= bus_s;
            if (ctrl_s[B_OI]) out_r <= bus_s;
            if (ctrl_s[B_J]) begin
                pc_r <= bus_s[3:0];
            end else if (ctrl_s[B_CE]) begin
                pc_r <= pc_r + 4'd1;
            end
            if (ctrl_s[B_FI]) begin
                carry_r <= alu_sum_s[8];
                zero_r  <= (alu_sum_s[7:0] == 8'h00);
            end
            step_r <= (step_r == 3'd4) ? 3'd0 : step_r + 3'd1;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && !halt_s && ctrl_s[B_RI]) begin
            ram[mar_r] <= bus_s;
        end
    end

    assign bus              = bus_s;
    assign mem_address_data = mar_r;
    assign mem_data         = mem_rd_s;
    assign a_data           = a_r;
    assign b_data           = b_r;
    assign alu_data         = alu_sum_s[7:0];
    assign instruction_data = ir_r;
    assign display_data     = out_r;
    assign pc_data          = pc_r;
    assign ctrl_state       = ctrl_s;
    assign ovf              = carry_r;
    assign zf               = zero_r;

endmodule

// File: tb/tb_eater_cpu.sv
// Directed bench for eater_cpu: ALU vector table plus hand-written jump, store, NOP-loop and reset sequences.
module tb_eater_cpu;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bus;
    logic [3:0]  mem_address_data;
    logic [7:0]  mem_data;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic [7:0]  alu_data;
    logic [7:0]  instruction_data;
    logic [7:0]  display_data;
    logic [3:0]  pc_data;
    logic [15:0] ctrl_state;
    logic        ovf;
    logic        zf;

    int checks = 0;
    int errors = 0;

    logic [7:0] prog [16];

    eater_cpu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .mem_address_data (mem_address_data),
        .mem_data         (mem_data),
        .a_data           (a_data),
        .b_data           (b_data),
        .alu_data         (alu_data),
        .instruction_data (instruction_data),
        .display_data     (display_data),
        .pc_data          (pc_data),
        .ctrl_state       (ctrl_state),
        .ovf              (ovf),
        .zf               (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a_in;
        logic [7:0] b_in;
        logic [7:0] exp_a;
        logic       exp_c;
        logic       exp_z;
    } alu_vec_t;

    alu_vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // Holds reset across one edge, loading the program into RAM meanwhile.
    task automatic reset_and_load();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) dut.ram[i] = prog[i];
        cycles(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        vecs[0] = '{8'h2F, 8'h1C, 8'h0E, 8'h2A, 1'b0, 1'b0};
        vecs[1] = '{8'h2F, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h2F, 8'h80, 8'h90, 8'h10, 1'b1, 1'b0};
        vecs[3] = '{8'h3F, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h3F, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h3F, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};

        // Reset state and first fetch step on zero RAM.
        clear_prog();
        cycles(1);
        reset_and_load();
        check("rst_pc", {12'h0, pc_data}, 16'h0000);
        check("rst_bus", {8'h0, bus}, 16'h0000);
        check("rst_ctrl", ctrl_state, 16'h4004);
        check("rst_mar", {12'h0, mem_address_data}, 16'h0000);
        check("rst_a", {8'h0, a_data}, 16'h0000);
        cycles(1);
        check("t1_ctrl", ctrl_state, 16'h1408);
        check("t1_bus", {8'h0, bus}, 16'h0000);

        // ALU table: LDA 14; ADD/SUB 15; OUT; HLT.
        for (int v = 0; v < 6; v++) begin
            clear_prog();
            prog[0] = 8'h1E; prog[1] = vecs[v].op; prog[2] = 8'hE0; prog[3] = 8'hF0;
            prog[14] = vecs[v].a_in; prog[15] = vecs[v].b_in;
            reset_and_load();
            cycles(15);
            check($sformatf("v%0d_disp15", v), {8'h0, display_data}, {8'h0, vecs[v].exp_a});
            cycles(2);
            check($sformatf("v%0d_ctrl17", v), ctrl_state, 16'h8000);
            cycles(3);
            check($sformatf("v%0d_a", v), {8'h0, a_data}, {8'h0, vecs[v].exp_a});
            check($sformatf("v%0d_ovf", v), {15'h0, ovf}, {15'h0, vecs[v].exp_c});
            check($sformatf("v%0d_zf", v), {15'h0, zf}, {15'h0, vecs[v].exp_z});
            check($sformatf("v%0d_pc", v), {12'h0, pc_data}, 16'h0004);
            cycles(10);
            check($sformatf("v%0d_frozen_ctrl", v), ctrl_state, 16'h8000);
            check($sformatf("v%0d_frozen_pc", v), {12'h0, pc_data}, 16'h0004);
            check($sformatf("v%0d_frozen_a", v), {8'h0, a_data}, {8'h0, vecs[v].exp_a});
        end

        // Taken JC then taken JZ after FF+01.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h75; prog[3] = 8'hF0; prog[4] = 8'hF0;
        prog[5] = 8'h89; prog[6] = 8'hF0; prog[7] = 8'hF0; prog[8] = 8'hF0;
        prog[9] = 8'hE0; prog[10] = 8'hF0;
        prog[14] = 8'hFF; prog[15] = 8'h01;
        reset_and_load();
        cycles(15);
        check("jc_taken_pc", {12'h0, pc_data}, 16'h0005);
        cycles(5);
        check("jz_taken_pc", {12'h0, pc_data}, 16'h0009);
        cycles(10);
        check("jz_halt_ctrl", ctrl_state, 16'h8000);
        check("jz_halt_pc", {12'h0, pc_data}, 16'h000B);

        // Reset while halted restarts at fetch.
        reset_and_load();
        check("halt_rst_ctrl", ctrl_state, 16'h4004);
        check("halt_rst_pc", {12'h0, pc_data}, 16'h0000);

        // Untaken JZ after 3-5.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h3F; prog[2] = 8'h89; prog[3] = 8'hE0; prog[4] = 8'hF0;
        prog[14] = 8'h03; prog[15] = 8'h05;
        reset_and_load();
        cycles(15);
        check("jz_untaken_pc", {12'h0, pc_data}, 16'h0003);
        cycles(5);
        check("jz_untaken_disp", {8'h0, display_data}, 16'h00FE);

        // STA 7 then LDA 7 round-trip through RAM.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h47; prog[2] = 8'h50; prog[3] = 8'h17; prog[4] = 8'hF0;
        prog[14] = 8'h5A;
        reset_and_load();
        cycles(10);
        check("sta_mar", {12'h0, mem_address_data}, 16'h0007);
        check("sta_mem", {8'h0, mem_data}, 16'h005A);
        cycles(5);
        check("ldi_a", {8'h0, a_data}, 16'h0000);
        cycles(5);
        check("lda_a", {8'h0, a_data}, 16'h005A);

        // NOP loop on zero RAM: PC steps once per 5 cycles and wraps.
        clear_prog();
        reset_and_load();
        cycles(5);
        check("nop_pc1", {12'h0, pc_data}, 16'h0001);
        cycles(70);
        check("nop_pc15", {12'h0, pc_data}, 16'h000F);
        cycles(5);
        check("nop_wrap", {12'h0, pc_data}, 16'h0000);
        cycles(7);
        check("nop_mid_ctrl", ctrl_state, 16'h0000);
        check("nop_mid_pc", {12'h0, pc_data}, 16'h0002);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        check("mid_rst_ctrl", ctrl_state, 16'h4004);
        check("mid_rst_pc", {12'h0, pc_data}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
